// File: rtl/rv32_exec_datapath_pkg.sv
// rv32_exec_datapath_pkg
// Shared encodings between the multicycle core FSM and the execute datapath:
// instruction format codes (fmt) and ALU operation codes (ALU_ctr).
package rv32_exec_datapath_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef enum logic [3:0] {
    FMT_R  = 4'd0,
    FMT_I  = 4'd1,
    FMT_IL = 4'd2,
    FMT_IE = 4'd3,
    FMT_S  = 4'd4,
    FMT_B  = 4'd5,
    FMT_J  = 4'd6,
    FMT_JI = 4'd7,
    FMT_U  = 4'd8,
    FMT_UP = 4'd9
  } fmt_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSA = 4'd10
  } alu_op_e;

endpackage

// File: rtl/rv32_exec_datapath_if.sv
// rv32_exec_datapath_if
// Bundle between the core control FSM (master) and the execute datapath (slave).
//   master drives : rs1, rs2, w, data_in, we, funct3, funct7, fmt, ALU_srcA, ALU_srcB
//   slave drives  : data_out1, data_out2, ALU_ctr, ALU_resp, zero
interface rv32_exec_datapath_if;
  import rv32_exec_datapath_pkg::*;

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      w;
  logic [XLEN-1:0] data_in;
  logic            we;
  logic [XLEN-1:0] data_out1;
  logic [XLEN-1:0] data_out2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [3:0]      fmt;
  logic [XLEN-1:0] ALU_srcA;
  logic [XLEN-1:0] ALU_srcB;
  logic [3:0]      ALU_ctr;
  logic [XLEN-1:0] ALU_resp;
  logic            zero;

  modport master (
    output rs1, rs2, w, data_in, we, funct3, funct7, fmt, ALU_srcA, ALU_srcB,
    input  data_out1, data_out2, ALU_ctr, ALU_resp, zero
  );

  modport slave (
    input  rs1, rs2, w, data_in, we, funct3, funct7, fmt, ALU_srcA, ALU_srcB,
    output data_out1, data_out2, ALU_ctr, ALU_resp, zero
  );

endinterface

// File: rtl/rv_regfile.sv
// rv_regfile
// 32 x 32 register file, two asynchronous read ports, one synchronous write port.
//   i_clk, i_reset            : clock, synchronous active-high reset (clears all registers)
//   i_rs1, i_rs2              : read indices
//   o_data_out1, o_data_out2  : read data (x0 reads 0; 0 while reset is asserted)
//   i_w, i_data_in, i_we      : write index, data, enable (writes to x0 dropped)
module rv_regfile
  import rv32_exec_datapath_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  input  logic [4:0]      i_w,
  input  logic [XLEN-1:0] i_data_in,
  input  logic            i_we,
  output logic [XLEN-1:0] o_data_out1,
  output logic [XLEN-1:0] o_data_out2
);

  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_w != 5'd0)) begin
      r_regs[i_w] <= i_data_in;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  // Reset gates the read ports so the core sees zeros throughout reset.
  assign o_data_out1 = (i_reset || i_rs1 == 5'd0) ? '0 : r_regs[i_rs1];
  assign o_data_out2 = (i_reset || i_rs2 == 5'd0) ? '0 : r_regs[i_rs2];

endmodule

// File: rtl/rv32_exec_datapath.sv
// rv32_exec_datapath
// Execute datapath of the multicycle RV32I core: register file, ALU-control
// decoder (combinational) and ALU with a one-cycle registered result.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of rv32_exec_datapath_if (register ports, funct/fmt
//                fields, ALU operands in; read data, ALU_ctr, ALU_resp, zero out)
module rv32_exec_datapath
  import rv32_exec_datapath_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  rv32_exec_datapath_if.slave  bus
);

  logic [XLEN-1:0] w_alu;
  alu_op_e         w_op;
  logic [XLEN-1:0] r_resp;
  logic            r_zero;
  logic            w_unused_funct7;

  rv_regfile u_regfile (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rs1       (bus.rs1),
    .i_rs2       (bus.rs2),
    .i_w         (bus.w),
    .i_data_in   (bus.data_in),
    .i_we        (bus.we),
    .o_data_out1 (bus.data_out1),
    .o_data_out2 (bus.data_out2)
  );

  // Only funct7[5] distinguishes ops in RV32I base.
  assign w_unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  function automatic alu_op_e decode(input logic [3:0] f, input logic [2:0] f3,
                                     input logic f7b5);
    alu_op_e op;
    op = ALU_ADD;
    case (f)
      FMT_R, FMT_I: begin
        case (f3)
          // funct7[5] in I-type ADDI is immediate data, not a SUB select.
          3'd0: op = (f == FMT_R && f7b5) ? ALU_SUB : ALU_ADD;
          3'd1: op = ALU_SLL;
          3'd2: op = ALU_SLT;
          3'd3: op = ALU_SLTU;
          3'd4: op = ALU_XOR;
          3'd5: op = f7b5 ? ALU_SRA : ALU_SRL;
          3'd6: op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      FMT_U:   op = ALU_PASSA;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  assign w_op        = decode(bus.fmt, bus.funct3, bus.funct7[5]);
  assign bus.ALU_ctr = w_op;

  always_comb begin
    w_alu = '0;
    case (w_op)
      ALU_ADD:   w_alu = bus.ALU_srcA + bus.ALU_srcB;
      ALU_SUB:   w_alu = bus.ALU_srcA - bus.ALU_srcB;
      ALU_SLL:   w_alu = bus.ALU_srcA << bus.ALU_srcB[4:0];
      ALU_SLT:   w_alu = {31'd0, $signed(bus.ALU_srcA) < $signed(bus.ALU_srcB)};
      ALU_SLTU:  w_alu = {31'd0, bus.ALU_srcA < bus.ALU_srcB};
      ALU_XOR:   w_alu = bus.ALU_srcA ^ bus.ALU_srcB;
      ALU_SRL:   w_alu = bus.ALU_srcA >> bus.ALU_srcB[4:0];
      ALU_SRA:   w_alu = $signed(bus.ALU_srcA) >>> bus.ALU_srcB[4:0];
      ALU_OR:    w_alu = bus.ALU_srcA | bus.ALU_srcB;
      ALU_AND:   w_alu = bus.ALU_srcA & bus.ALU_srcB;
      ALU_PASSA: w_alu = bus.ALU_srcA;
      default:   w_alu = '0;
    endcase
  end

  // Result is held one cycle so the FSM can zero the operands in its next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp <= '0;
      r_zero <= 1'b1;
    end else begin
      r_resp <= w_alu;
      r_zero <= (w_alu == '0);
    end
  end

  assign bus.ALU_resp = r_resp;
  assign bus.zero     = r_zero;

endmodule

// File: tb/tb_rv32_exec_datapath.sv
module tb_rv32_exec_datapath;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32_exec_datapath_if bus ();

  rv32_exec_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_regs [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ALU operation number the instruction fields call for.
  function automatic logic [3:0] ref_ctr(input logic [3:0] f, input logic [2:0] f3,
                                         input logic [6:0] f7);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (f == 4'd0 || f == 4'd1) begin
      if (f3 == 3'd0) return (f == 4'd0 && f7[5]) ? 4'd1 : 4'd0;
      if (f3 == 3'd5) return f7[5] ? 4'd7 : 4'd6;
      return tbl[f3];
    end
    if (f == 4'd8) return 4'd10;
    return 4'd0;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int s;
    longint sa, sb;
    s  = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << s;
      4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> s;
      4'd7:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return a;
      default: return 32'd0;
    endcase
  endfunction

  // Called just after a rising edge with inputs already driven; runs one cycle.
  task automatic step();
    logic [3:0]  ectr;
    logic [31:0] eres;
    @(negedge clk);
    ectr = ref_ctr(bus.fmt, bus.funct3, bus.funct7);
    chk("alu_ctr", {28'd0, bus.ALU_ctr}, {28'd0, ectr});
    chk("rd1", bus.data_out1, (reset || bus.rs1 == 0) ? 32'd0 : m_regs[bus.rs1]);
    chk("rd2", bus.data_out2, (reset || bus.rs2 == 0) ? 32'd0 : m_regs[bus.rs2]);
    eres = ref_alu(ectr, bus.ALU_srcA, bus.ALU_srcB);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else if (bus.we && bus.w != 0) begin
      m_regs[bus.w] = bus.data_in;
    end
    #1;
    chk("alu_resp", bus.ALU_resp, reset ? 32'd0 : eres);
    chk("zero", {31'd0, bus.zero}, {31'd0, reset ? 1'b1 : (eres == 32'd0)});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'hDEAD_BEEF;
    reset = 1'b1;
    bus.rs1 = 0; bus.rs2 = 0; bus.w = 0; bus.data_in = 0; bus.we = 0;
    bus.funct3 = 0; bus.funct7 = 0; bus.fmt = 0; bus.ALU_srcA = 0; bus.ALU_srcB = 0;
    @(posedge clk); #1;
    step();
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      bus.rs1 = 5'(i); bus.rs2 = 5'(31 - i);
      step();
    end

    // write x5; same-cycle read returns old value
    bus.rs1 = 5; bus.w = 5; bus.we = 1; bus.data_in = 32'h1234_5678;
    step();
    bus.we = 0;
    @(negedge clk);
    chk("x5_after_write", bus.data_out1, 32'h1234_5678);
    @(posedge clk); #1;

    // x0 stays zero
    bus.rs1 = 0; bus.w = 0; bus.we = 1; bus.data_in = 32'hFFFF_FFFF;
    step();
    bus.we = 0;
    @(negedge clk);
    chk("x0_read", bus.data_out1, 32'd0);
    @(posedge clk); #1;

    // R-type SUB
    bus.fmt = 0; bus.funct3 = 0; bus.funct7 = 7'h20; bus.ALU_srcA = 5; bus.ALU_srcB = 7;
    step();
    chk("sub_resp", bus.ALU_resp, 32'hFFFF_FFFE);
    chk("sub_zero", {31'd0, bus.zero}, 32'd0);
    bus.ALU_srcA = 3; bus.ALU_srcB = 3;
    step();
    chk("sub_eq_zero", {31'd0, bus.zero}, 32'd1);

    // ADDI with negative immediate, funct7[5] set
    bus.fmt = 1; bus.funct3 = 0; bus.funct7 = 7'h7F; bus.ALU_srcA = 10; bus.ALU_srcB = 32'hFFFF_FFFF;
    step();
    chk("addi_resp", bus.ALU_resp, 32'd9);

    // SRAI
    bus.fmt = 1; bus.funct3 = 5; bus.funct7 = 7'h20; bus.ALU_srcA = 32'h8000_0000; bus.ALU_srcB = 4;
    step();
    chk("srai_resp", bus.ALU_resp, 32'hF800_0000);

    // LUI, hold, then AUIPC-style add
    bus.fmt = 8; bus.funct3 = 0; bus.funct7 = 0; bus.ALU_srcA = 32'hABCD_E000; bus.ALU_srcB = 12;
    step();
    chk("lui_resp", bus.ALU_resp, 32'hABCD_E000);
    bus.ALU_srcA = 0; bus.ALU_srcB = 0;
    #2;
    chk("lui_hold", bus.ALU_resp, 32'hABCD_E000);
    step();
    chk("lui_next", bus.ALU_resp, 32'd0);
    bus.fmt = 9; bus.ALU_srcA = 32'hABCD_E000; bus.ALU_srcB = 32'h100;
    step();
    chk("auipc_resp", bus.ALU_resp, 32'hABCD_E100);

    // reset beats a simultaneous write
    bus.w = 7; bus.we = 1; bus.data_in = 32'hCAFE_F00D; bus.rs1 = 5; reset = 1;
    step();
    reset = 0; bus.we = 0; bus.rs1 = 7; bus.rs2 = 5;
    step();

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      bus.fmt      = 4'($urandom_range(0, 15));
      bus.funct3   = 3'($urandom);
      bus.funct7   = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'($urandom);
      bus.ALU_srcA = ($urandom_range(0, 7) == 0) ? bus.ALU_srcB : $urandom;
      bus.ALU_srcB = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      bus.rs1      = 5'($urandom);
      bus.rs2      = 5'($urandom);
      bus.w        = 5'($urandom);
      bus.we       = 1'($urandom);
      bus.data_in  = $urandom;
      reset        = ($urandom_range(0, 60) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
